frame_stimulus_gen: RTL and testbench
=====================================

# frame_stimulus_gen

- Parametrised synthetic frame source for the motion-tracker datapath.
- Replaces fixed two-value luminance stimulus with a raster-ordered frame generator: configurable frame size, pixel-strobe rate, pattern mode, frame count and start/stop control.
- Drives the luminance input of the frame array and motion detector in simulation and on-board self-test.
- Every emitted pixel is marked by a one-cycle latch strobe; frame and line boundaries are flagged.

## Interface
- DATA_W, 8: luminance width.
- H_ACTIVE, 640: pixels per line (≥2).
- V_ACTIVE, 480: lines per frame (≥2).
- STROBE_DIV, 2: clock cycles per pixel strobe (≥1).
- NUM_FRAMES, 0: frames per run; 0 = run until iStop.
- FIRST_VAL, 8'h01 / BG_VAL, 8'hFF / FG_VAL, 8'h00: pattern values.
- BOX_SIZE, 16; BOX_Y, 232; BOX_STEP, 4: moving-box geometry (pixels).
- CHK_LOG2, 3: checkerboard cell = 2^CHK_LOG2 pixels.
- iClock in 1: system clock, all logic on rising edge.
- iReset in 1: synchronous, active-low reset.
- iStart in 1: start a run (sampled in IDLE only).
- iStop in 1: request stop at end of current frame (level or pulse).
- iMode in 2: 0 first/background, 1 ramp, 2 moving box, 3 checkerboard.
- oEnLatch out 1: one-cycle pixel strobe; oYdata valid when high.
- oYdata out DATA_W: pixel luminance, held between strobes.
- oFrameStart out 1: high with the strobe of pixel (0,0).
- oLineStart out 1: high with the strobe of pixel (0,y).
- oFrameDone out 1: high with the strobe of pixel (H_ACTIVE-1,V_ACTIVE-1).
- oBusy out 1: high in RUN.
- oFrameCount out 16: frames fully emitted this run, wraps at 2^16.

## Operation
- States IDLE, RUN. Reset → IDLE, all outputs 0, pixel/line/divider/frame counters 0, stop latch clear.
- IDLE: iStart=1 → RUN; latch iMode into mode register; clear x, y, divider, frame index, oFrameCount.
- RUN: divider counts 0..STROBE_DIV-1; at STROBE_DIV-1 emit pixel (x,y), advance x; x wrap → x=0, y+1; y wrap at end of frame → frame complete.
- Mode 0: frame index 0 all FIRST_VAL; later frames all BG_VAL.
- Mode 1: oYdata = (x + frame index) mod 2^DATA_W.
- Mode 2: FG_VAL where bx ≤ x < bx+BOX_SIZE and BOX_Y ≤ y < BOX_Y+BOX_SIZE, else BG_VAL. bx = 0 in frame 0, +BOX_STEP per frame, mod H_ACTIVE. Box clipped at right edge, no wrap to left.
- Mode 3: FG_VAL when ((x>>CHK_LOG2) ^ (y>>CHK_LOG2) ^ frame index[0]) & 1, else BG_VAL (checkerboard inverts each frame).
- Frame complete: oFrameCount+1, frame index+1, iMode re-sampled for next frame. Then IDLE if stop latch set or NUM_FRAMES≠0 and count reached NUM_FRAMES; otherwise continue with x=y=0 without gap.
- iStop sampled any RUN cycle sets stop latch; cleared on entering IDLE. iStart in RUN ignored.
- iStop and frame completion same cycle: stop honoured at that boundary.

## Timing
- iStart sampled at edge E0: oBusy high after E0; first strobe (pixel 0,0) high in the cycle after edge E0+STROBE_DIV.
- Strobe period exactly STROBE_DIV cycles; STROBE_DIV=1 → oEnLatch continuously high in RUN.
- oYdata, oFrameStart, oLineStart, oFrameDone all registered, updated on the same edge as oEnLatch rises.
- Markers high only with oEnLatch; oYdata holds last value after the strobe and in IDLE.
- oFrameCount increments on the edge after the oFrameDone strobe cycle.
- Return to IDLE (oBusy low) on the edge ending the final oFrameDone strobe cycle + STROBE_DIV-1 cycles.
- Back-to-back frames: next oFrameStart exactly STROBE_DIV cycles after oFrameDone.
- iReset low mid-frame: next edge all outputs 0, state IDLE; no partial oFrameDone.

## Test plan
- H=4,V=3,DIV=2,NUM_FRAMES=2, mode 0, iStart pulse → 12 strobes of 8'h01 every 2 cycles, oFrameDone on 12th, then 12 of 8'hFF, oFrameCount=2, oBusy low.
- Mode 1, H=4,V=2,DIV=1 → frame0 oYdata 0,1,2,3,0,1,2,3; frame1 1,2,3,4,…; oLineStart on strobes 1 and 5.
- Mode 2, H=8,V=4,BOX_SIZE=2,BOX_Y=1,BOX_STEP=3 → FG at x∈{0,1} frame0, {3,4} frame1, {6,7} frame2, {1,2} frame3 (wrap), rows 1–2 only.
- NUM_FRAMES=0, iStop mid frame 1 → frame 1 completes; oFrameCount=2; no strobe after oFrameDone.
- iStop coincident with oFrameDone → stop at that boundary; oFrameCount counts that frame.
- iReset low at pixel 5 of frame 0 → next cycle oEnLatch=0, oYdata=0, oBusy=0, oFrameCount=0; iStart restarts at pixel (0,0).

Source files
------------

// File: rtl/frame_stimulus_gen.sv
// Synthetic raster frame source for the motion-tracker datapath.
// It emits one pixel every STROBE_DIV clocks in raster order. The pixel value
// depends on the selected pattern, and the first-pixel, line-start and
// last-pixel markers are registered together with the strobe.
module frame_stimulus_gen #(
  parameter int                DATA_W     = 8,
  parameter int                H_ACTIVE   = 640,
  parameter int                V_ACTIVE   = 480,
  parameter int                STROBE_DIV = 2,
  parameter int                NUM_FRAMES = 0,
  parameter logic [DATA_W-1:0] FIRST_VAL  = DATA_W'(8'h01),
  parameter logic [DATA_W-1:0] BG_VAL     = DATA_W'(8'hFF),
  parameter logic [DATA_W-1:0] FG_VAL     = DATA_W'(8'h00),
  parameter int                BOX_SIZE   = 16,
  parameter int                BOX_Y      = 232,
  parameter int                BOX_STEP   = 4,
  parameter int                CHK_LOG2   = 3
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStart,
  input  logic              iStop,
  input  logic [1:0]        iMode,
  output logic              oEnLatch,
  output logic [DATA_W-1:0] oYdata,
  output logic              oFrameStart,
  output logic              oLineStart,
  output logic              oFrameDone,
  output logic              oBusy,
  output logic [15:0]       oFrameCount
);

  localparam int X_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int D_W  = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
  localparam int XP_W = X_W + 1;

  localparam logic [X_W-1:0]  X_LAST   = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [D_W-1:0]  D_LAST   = D_W'(STROBE_DIV - 1);
  localparam logic [X_W-1:0]  STEP_MOD = X_W'(BOX_STEP % H_ACTIVE);
  localparam logic [X_W:0]    H_EXT    = XP_W'(H_ACTIVE);
  localparam logic [15:0]     NUM_FR   = 16'(NUM_FRAMES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [D_W-1:0]    div_q, div_d;
  logic [15:0]       fidx_q, fidx_d;
  logic [X_W-1:0]    bx_q, bx_d;
  logic              stop_q, stop_d;
  logic              bound_q, bound_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] ydata_q, ydata_d;
  logic              fs_q, fs_d;
  logic              ls_q, ls_d;
  logic              fd_q, fd_d;
  logic [15:0]       fcnt_q, fcnt_d;

  logic [31:0]       x_w, y_w, bx_w;
  logic              in_box;
  logic              chk_bit;
  logic [X_W:0]      bx_sum;
  logic [X_W-1:0]    bx_next;
  logic [DATA_W-1:0] pix_val;
  logic              stop_set;

  assign x_w  = 32'(x_q);
  assign y_w  = 32'(y_q);
  assign bx_w = 32'(bx_q);

  // The box is clipped at the right edge because x never reaches bx+BOX_SIZE past H_ACTIVE.
  assign in_box = (x_w >= bx_w) && (x_w < bx_w + 32'(BOX_SIZE)) &&
                  (y_w >= 32'(BOX_Y)) && (y_w < 32'(BOX_Y) + 32'(BOX_SIZE));

  assign chk_bit = |(((x_w >> CHK_LOG2) ^ (y_w >> CHK_LOG2) ^ {31'd0, fidx_q[0]}) & 32'd1);

  // The box origin advances by a step that is pre-reduced mod H_ACTIVE, so one conditional subtract suffices.
  assign bx_sum  = {1'b0, bx_q} + {1'b0, STEP_MOD};
  assign bx_next = (bx_sum >= H_EXT) ? X_W'(bx_sum - H_EXT) : bx_sum[X_W-1:0];

  // Pattern value for the pixel at (x_q, y_q) in the current frame
  always_comb begin
    pix_val = BG_VAL;
    case (mode_q)
      2'd0:    pix_val = (fidx_q == '0) ? FIRST_VAL : BG_VAL;
      2'd1:    pix_val = DATA_W'(x_w + 32'(fidx_q));
      2'd2:    pix_val = in_box ? FG_VAL : BG_VAL;
      default: pix_val = chk_bit ? FG_VAL : BG_VAL;
    endcase
  end

  // Run control, raster counters and registered pixel outputs
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    x_d      = x_q;
    y_d      = y_q;
    div_d    = div_q;
    fidx_d   = fidx_q;
    bx_d     = bx_q;
    stop_d   = stop_q;
    bound_d  = bound_q;
    en_d     = 1'b0;
    ydata_d  = ydata_q;
    fs_d     = 1'b0;
    ls_d     = 1'b0;
    fd_d     = 1'b0;
    fcnt_d   = fidx_q;
    stop_set = stop_q | iStop;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_RUN;
          mode_d  = iMode;
          x_d     = '0;
          y_d     = '0;
          div_d   = '0;
          fidx_d  = '0;
          bx_d    = '0;
          stop_d  = 1'b0;
          bound_d = 1'b0;
          fcnt_d  = '0;
        end
      end
      default: begin
        stop_d = stop_set;
        if (div_q == D_LAST) begin
          div_d = '0;
          // The run-end decision is taken in the slot where the next frame's first pixel would go.
          if (bound_q && (stop_set || ((NUM_FRAMES != 0) && (fidx_q == NUM_FR)))) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
            bound_d = 1'b0;
          end else begin
            bound_d = 1'b0;
            en_d    = 1'b1;
            ydata_d = pix_val;
            fs_d    = (x_q == '0) && (y_q == '0);
            ls_d    = (x_q == '0);
            if (x_q == X_LAST) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                y_d     = '0;
                fd_d    = 1'b1;
                bound_d = 1'b1;
                fidx_d  = fidx_q + 16'd1;
                bx_d    = bx_next;
                mode_d  = iMode;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      div_q   <= '0;
      fidx_q  <= '0;
      bx_q    <= '0;
      stop_q  <= 1'b0;
      bound_q <= 1'b0;
      en_q    <= 1'b0;
      ydata_q <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      fd_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      div_q   <= div_d;
      fidx_q  <= fidx_d;
      bx_q    <= bx_d;
      stop_q  <= stop_d;
      bound_q <= bound_d;
      en_q    <= en_d;
      ydata_q <= ydata_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      fd_q    <= fd_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign oEnLatch    = en_q;
  assign oYdata      = ydata_q;
  assign oFrameStart = fs_q;
  assign oLineStart  = ls_q;
  assign oFrameDone  = fd_q;
  assign oBusy       = (state_q == S_RUN);
  assign oFrameCount = fcnt_q;

endmodule

// File: tb/tb_frame_stimulus_gen.sv
// Bench for frame_stimulus_gen: three differently sized instances share one
// stimulus stream. Each instance is compared every cycle against a pixel-index
// reference model.
module tb_frame_stimulus_gen;

  localparam int H_P  [3] = '{4, 8, 4};
  localparam int V_P  [3] = '{3, 4, 2};
  localparam int D_P  [3] = '{2, 1, 1};
  localparam int NF_P [3] = '{2, 0, 0};
  localparam int BSIZE = 2;
  localparam int BY    = 1;
  localparam int BSTEP = 3;
  localparam int CHK   = 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;

  wire [2:0]       en_o, fs_o, ls_o, fd_o, busy_o;
  wire [2:0][7:0]  y_o;
  wire [2:0][15:0] fc_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state, one slot per instance
  logic [2:0]       m_busy, m_en, m_fs, m_ls, m_fd, m_stop, m_pend;
  logic [2:0][7:0]  m_y;
  logic [2:0][15:0] m_fc;
  int               m_t    [3];
  int               m_mode [3];

  frame_stimulus_gen #(.DATA_W(8), .H_ACTIVE(4), .V_ACTIVE(3), .STROBE_DIV(2), .NUM_FRAMES(2),
    .BOX_SIZE(2), .BOX_Y(1), .BOX_STEP(3), .CHK_LOG2(1)) u_dut0 (
    .iClock(clk), .iReset(rst_n), .iStart(start), .iStop(stop), .iMode(mode),
    .oEnLatch(en_o[0]), .oYdata(y_o[0]), .oFrameStart(fs_o[0]), .oLineStart(ls_o[0]),
    .oFrameDone(fd_o[0]), .oBusy(busy_o[0]), .oFrameCount(fc_o[0]));

  frame_stimulus_gen #(.DATA_W(8), .H_ACTIVE(8), .V_ACTIVE(4), .STROBE_DIV(1), .NUM_FRAMES(0),
    .BOX_SIZE(2), .BOX_Y(1), .BOX_STEP(3), .CHK_LOG2(1)) u_dut1 (
    .iClock(clk), .iReset(rst_n), .iStart(start), .iStop(stop), .iMode(mode),
    .oEnLatch(en_o[1]), .oYdata(y_o[1]), .oFrameStart(fs_o[1]), .oLineStart(ls_o[1]),
    .oFrameDone(fd_o[1]), .oBusy(busy_o[1]), .oFrameCount(fc_o[1]));

  frame_stimulus_gen #(.DATA_W(8), .H_ACTIVE(4), .V_ACTIVE(2), .STROBE_DIV(1), .NUM_FRAMES(0),
    .BOX_SIZE(2), .BOX_Y(1), .BOX_STEP(3), .CHK_LOG2(1)) u_dut2 (
    .iClock(clk), .iReset(rst_n), .iStart(start), .iStop(stop), .iMode(mode),
    .oEnLatch(en_o[2]), .oYdata(y_o[2]), .oFrameStart(fs_o[2]), .oLineStart(ls_o[2]),
    .oFrameDone(fd_o[2]), .oBusy(busy_o[2]), .oFrameCount(fc_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int i, input int md, input int f, input int x, input int y);
    int bx;
    case (md)
      0: return (f == 0) ? 8'h01 : 8'hFF;
      1: return 8'((x + f) % 256);
      2: begin
        bx = (f * BSTEP) % H_P[i];
        return (x >= bx && x < bx + BSIZE && y >= BY && y < BY + BSIZE) ? 8'h00 : 8'hFF;
      end
      default: return ((((x >> CHK) ^ (y >> CHK) ^ f) & 1) != 0) ? 8'h00 : 8'hFF;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs the DUTs just sampled.
  // Pixel k of a run is emitted at edge start + D*(k+1).
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int hv, k, f, p;
      hv = H_P[i] * V_P[i];
      m_en[i] = 1'b0; m_fs[i] = 1'b0; m_ls[i] = 1'b0; m_fd[i] = 1'b0;
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_y[i] = '0; m_fc[i] = '0; m_stop[i] = 1'b0; m_pend[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (start) begin
          m_busy[i] = 1'b1; m_t[i] = 0; m_stop[i] = 1'b0; m_pend[i] = 1'b0;
          m_fc[i] = '0; m_mode[i] = int'(mode);
        end
      end else begin
        m_t[i]++;
        if (stop) m_stop[i] = 1'b1;
        if (m_pend[i]) begin m_fc[i] = m_fc[i] + 16'd1; m_pend[i] = 1'b0; end
        if (m_t[i] % D_P[i] == 0) begin
          k = m_t[i] / D_P[i] - 1;
          f = k / hv;
          p = k % hv;
          if (k > 0 && p == 0 && (m_stop[i] || (NF_P[i] != 0 && f == NF_P[i]))) begin
            m_busy[i] = 1'b0;
          end else begin
            m_en[i] = 1'b1;
            m_y[i]  = pix(i, m_mode[i], f, p % H_P[i], p / H_P[i]);
            m_fs[i] = (p == 0);
            m_ls[i] = (p % H_P[i] == 0);
            if (p == hv - 1) begin
              m_fd[i] = 1'b1; m_pend[i] = 1'b1; m_mode[i] = int'(mode);
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] obs=%0h exp=%0h at %0t", tag, inst, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("en",    i, 16'(en_o[i]),   16'(m_en[i]));
      chk("ydata", i, 16'(y_o[i]),    16'(m_y[i]));
      chk("fstart",i, 16'(fs_o[i]),   16'(m_fs[i]));
      chk("lstart",i, 16'(ls_o[i]),   16'(m_ls[i]));
      chk("fdone", i, 16'(fd_o[i]),   16'(m_fd[i]));
      chk("busy",  i, 16'(busy_o[i]), 16'(m_busy[i]));
      chk("fcount",i, fc_o[i],        m_fc[i]);
    end
  endtask

  task automatic wait_idle(input logic [2:0] mask, input int budget);
    int n;
    n = 0;
    while ((m_busy & mask) != 3'b000 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 0, 16'(busy_o & mask), 16'd0);
  endtask

  task automatic pulse_start(input logic [1:0] md);
    mode = md; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, cnt;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    m_busy = '0; m_en = '0; m_fs = '0; m_ls = '0; m_fd = '0; m_stop = '0; m_pend = '0;
    m_y = '0; m_fc = '0;
    for (int i = 0; i < 3; i++) begin m_t[i] = 0; m_mode[i] = 0; end

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Mode 0: instance 0 stops by itself after two frames
    pulse_start(2'd0);
    wait_idle(3'b001, 100);
    chk("m0_fcount", 0, fc_o[0], 16'd2);
    chk("m0_last",   0, 16'(y_o[0]), 16'h00FF);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(3'b111, 200);

    // Mode 1 ramp with a stop pulse in the middle of instance 2's second frame
    pulse_start(2'd1);
    repeat (12) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(3'b111, 200);
    chk("m1_fcount", 2, fc_o[2], 16'd2);

    // Mode 2 moving box across five frames of instance 1, including the wrap of bx
    pulse_start(2'd2);
    repeat (140) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(3'b111, 200);

    // Mode 3 with stop coincident with instance 2's oFrameDone strobe
    pulse_start(2'd3);
    n = 0;
    while (!m_fd[2] && n < 50) begin tick(); n++; end
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(3'b111, 200);
    chk("coinc_fcount", 2, fc_o[2], 16'd1);

    // Same for instance 0, whose strobe divider is 2
    pulse_start(2'd3);
    n = 0;
    while (!m_fd[0] && n < 100) begin tick(); n++; end
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(3'b111, 200);
    chk("coinc_fcount", 0, fc_o[0], 16'd1);

    // Reset after the fifth pixel of instance 0, then restart
    pulse_start(2'd1);
    cnt = 0; n = 0;
    while (cnt < 5 && n < 40) begin tick(); n++; if (m_en[0]) cnt++; end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_en",    0, 16'(en_o[0]),   16'd0);
    chk("rst_ydata", 0, 16'(y_o[0]),    16'd0);
    chk("rst_busy",  0, 16'(busy_o[0]), 16'd0);
    chk("rst_fcount",0, fc_o[0],        16'd0);
    pulse_start(2'd1);
    n = 0;
    while (!m_en[0] && n < 10) begin tick(); n++; end
    chk("restart_fs", 0, 16'(fs_o[0]), 16'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(3'b111, 200);

    // Randomised control traffic
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    start = 1'b0; rst_n = 1'b1; stop = 1'b1;
    wait_idle(3'b111, 200);
    stop = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
